fault_mem_cfg: RTL and testbench
================================

FAULT_MEM_CFG -- requirements
Module: fault_mem_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (minimum 2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width; array depth is DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port write_read  input  1  1 = write, 0 = read.
REQ-006 SHALL have port address  input  ADDR_WIDTH  word address.
REQ-007 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-008 SHALL have port rdata  output  DATA_WIDTH  registered read data.
REQ-009 SHALL have port fault_load  input  1  pulse that latches the fault configuration.
REQ-010 SHALL have port fault_type  input  3  fault selector, encoded per REQ-016.
REQ-011 SHALL have port fault_addr  input  ADDR_WIDTH  victim word address.
REQ-012 SHALL have port fault_bit  input  $clog2(DATA_WIDTH)  victim bit index.
REQ-013 SHALL have port fault_armed  output  1  latched fault_type is non-zero.
REQ-014 SHALL have port fault_hits  output  8  fault activation counter (see Configuration).

Function
REQ-015 SHALL latch fault_type, fault_addr and fault_bit on an edge where fault_load=1; a fault_bit value >= DATA_WIDTH is stored as 0.
REQ-016 SHALL use the encoding 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 transition-up (0->1 write fails), 4 transition-down (1->0 write fails), 5 coupling, 6 NPSF, 7 treated as none.
REQ-017 SHALL register write_read, address and wdata at edge N (request stage) and commit the write to the array at edge N+1.
REQ-018 SHALL perform a read requested at edge N by loading the array word into an internal stage at edge N+1 and driving it on rdata at edge N+2, giving a latency of 2.
REQ-019 SHALL forward the post-fault committed word when a read at the internal stage targets the address being committed on the same edge.
REQ-020 SHALL force victim bit fault_bit of fault_addr to the stuck value on the read path for stuck-at faults (types 1 and 2), independent of stored content.
REQ-021 SHALL preserve the stored victim bit for transition faults (types 3 and 4) when a committed write attempts the failing transition.
REQ-022 SHALL set the victim bit to 1 for a coupling fault (type 5) when a write to aggressor address fault_addr-1 changes that aggressor's bit fault_bit from 0 to 1; with fault_addr=0 there is no aggressor and no wrap-around.
REQ-023 SHALL store 0 in the victim bit for an NPSF fault (type 6) when writing fault_addr while bit fault_bit of both fault_addr-1 and fault_addr+1 is 1; out-of-range neighbours at addresses 0 and DEPTH-1 read as 0 and the fault never triggers there.
REQ-024 SHALL apply to each commit the configuration latched before that edge, so a fault_load on the commit edge does not affect that write.
REQ-025 SHALL leave all non-victim bits and addresses behaving as an ideal memory.

Reset
REQ-026 SHALL clear rdata, the internal stages, the latched configuration (type 0), fault_armed and fault_hits to 0 while rst=1.
REQ-027 SHALL not reset the array contents, and SHALL discard any pending commit or read when rst is asserted mid-operation.

Configuration
REQ-028 SHALL, with macro FAULT_MEM_HIT_CNT_EN defined, increment fault_hits (saturating at 255) on each edge where a fault changes a committed or read-path bit versus ideal behaviour.
REQ-029 SHALL, without FAULT_MEM_HIT_CNT_EN, tie fault_hits to constant 0 and omit the counter logic.

Verification
REQ-030 SHALL cover: type 0; write 0xA5 to addr 3, then read addr 3 -> rdata=0xA5 exactly 2 cycles after the read request.
REQ-031 SHALL cover: load type 2, addr 5, bit 0; write 0x00 to addr 5; read -> rdata=0x01; fault_hits=1 when enabled.
REQ-032 SHALL cover: load type 6, addr 4, bit 1; write 0x02 to addrs 3 and 5; write 0xFF to addr 4; read -> 0xFD; repeat at addr 0 -> 0xFF.
REQ-033 SHALL cover: load type 5, addr 7, bit 2; write 0x00 to addr 7, then 0x04 to addr 6; read addr 7 -> 0x04; with addr 0, no victim changes.
REQ-034 SHALL cover: write to addr 2, then a back-to-back read of addr 2 -> forwarded value; assert rst between request and commit -> array unchanged, rdata=0.

Source files
------------

// File: rtl/fault_mem_cfg.sv
// Word memory with one configurable injected fault (stuck-at, transition, coupling, NPSF); 2-cycle read latency, no backpressure.
// Define FAULT_MEM_HIT_CNT_EN to build the saturating fault activation counter on fault_hits.
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_read,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  input  logic                          fault_load,
  input  logic [2:0]                    fault_type,
  input  logic [ADDR_WIDTH-1:0]         fault_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] fault_bit,
  output logic                          fault_armed,
  output logic [7:0]                    fault_hits
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BW    = $clog2(DATA_WIDTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [2:0] {
    FT_NONE  = 3'd0,
    FT_SA0   = 3'd1,
    FT_SA1   = 3'd2,
    FT_TUP   = 3'd3,
    FT_TDN   = 3'd4,
    FT_CPL   = 3'd5,
    FT_NPSF  = 3'd6,
    FT_NONE7 = 3'd7
  } fault_e;

  localparam addr_t ADDR_MAX = addr_t'(DEPTH - 1);

  word_t   mem [DEPTH];

  fault_e  cfg_type;
  addr_t   cfg_addr;
  logic [BW-1:0] cfg_bit;

  logic    req_vld;
  logic    req_wr;
  addr_t   req_addr;
  word_t   req_wdata;

  logic    rd_vld;
  word_t   rd_stage;

  logic    commit_en;
  logic    rd_en;
  logic    cpl_set;
  word_t   old_word;
  word_t   commit_word;
  word_t   rd_raw;
  word_t   rd_word;
  addr_t   nbr_lo;
  addr_t   nbr_hi;
  logic    has_lo;
  logic    has_hi;

  assign nbr_lo      = cfg_addr - 1'b1;
  assign nbr_hi      = cfg_addr + 1'b1;
  assign has_lo      = (cfg_addr != '0);
  assign has_hi      = (cfg_addr != ADDR_MAX);
  assign commit_en   = req_vld && req_wr;
  assign rd_en       = req_vld && !req_wr;
  assign fault_armed = (cfg_type != FT_NONE);

  // Commit path: the word (and possibly a coupled victim bit) written on the next edge.
  always_comb begin
    old_word    = mem[req_addr];
    commit_word = req_wdata;
    cpl_set     = 1'b0;
    case (cfg_type)
      FT_TUP: begin
        if (req_addr == cfg_addr && !old_word[cfg_bit] && req_wdata[cfg_bit])
          commit_word[cfg_bit] = 1'b0;
      end
      FT_TDN: begin
        if (req_addr == cfg_addr && old_word[cfg_bit] && !req_wdata[cfg_bit])
          commit_word[cfg_bit] = 1'b1;
      end
      FT_CPL: begin
        if (has_lo && req_addr == nbr_lo && !old_word[cfg_bit] && req_wdata[cfg_bit])
          cpl_set = 1'b1;
      end
      FT_NPSF: begin
        if (req_addr == cfg_addr && has_lo && has_hi &&
            mem[nbr_lo][cfg_bit] && mem[nbr_hi][cfg_bit])
          commit_word[cfg_bit] = 1'b0;
      end
      default: ;
    endcase
  end

  // Read path: a same-edge commit to the read address wins over the array, then stuck-at forcing.
  always_comb begin
    rd_raw  = commit_en ? commit_word : mem[req_addr];
    rd_word = rd_raw;
    if ((cfg_type == FT_SA0 || cfg_type == FT_SA1) && req_addr == cfg_addr)
      rd_word[cfg_bit] = (cfg_type == FT_SA1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_vld   <= 1'b0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rd_vld    <= 1'b0;
      rd_stage  <= '0;
      rdata     <= '0;
      cfg_type  <= FT_NONE;
      cfg_addr  <= '0;
      cfg_bit   <= '0;
    end else begin
      req_vld   <= 1'b1;
      req_wr    <= write_read;
      req_addr  <= address;
      req_wdata <= wdata;
      rd_vld    <= rd_en;
      if (rd_en)
        rd_stage <= rd_word;
      if (rd_vld)
        rdata <= rd_stage;
      if (fault_load) begin
        cfg_type <= fault_e'(fault_type);
        cfg_addr <= fault_addr;
        cfg_bit  <= (int'(fault_bit) >= DATA_WIDTH) ? '0 : fault_bit;
      end
    end
  end

  // Array contents survive reset; a commit pending on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && commit_en) begin
      mem[req_addr] <= commit_word;
      if (cpl_set)
        mem[cfg_addr][cfg_bit] <= 1'b1;
    end
  end

`ifdef FAULT_MEM_HIT_CNT_EN
  logic       hit_now;
  logic [7:0] hit_cnt;

  assign hit_now = (commit_en && ((commit_word != req_wdata) ||
                                  (cpl_set && !mem[cfg_addr][cfg_bit]))) ||
                   (rd_en && (rd_word != rd_raw));

  always_ff @(posedge clk) begin
    if (rst)
      hit_cnt <= '0;
    else if (hit_now && hit_cnt != 8'hFF)
      hit_cnt <= hit_cnt + 8'd1;
  end

  assign fault_hits = hit_cnt;
`else
  assign fault_hits = 8'd0;
`endif

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Scoreboard bench for fault_mem_cfg: reads push expected words, the 2-cycle-late rdata pops them.
module tb_fault_mem_cfg;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam logic [AW-1:0] IDLE_ADDR = 4'd15;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_read;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          fault_load;
  logic [2:0]    fault_type;
  logic [AW-1:0] fault_addr;
  logic [2:0]    fault_bit;
  logic          fault_armed;
  logic [7:0]    fault_hits;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] exp_q[$];
  string         tag_q[$];
  logic          rd_issue = 1'b0;
  logic [2:0]    rd_sh = 3'b000;

  always #5 clk = ~clk;

  fault_mem_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .write_read (write_read),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .fault_load (fault_load),
    .fault_type (fault_type),
    .fault_addr (fault_addr),
    .fault_bit  (fault_bit),
    .fault_armed(fault_armed),
    .fault_hits (fault_hits)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Track reads through the two pipeline edges; compare once rdata has updated.
  always @(posedge clk) rd_sh <= rst ? 3'b000 : {rd_sh[1:0], rd_issue};

  always @(negedge clk) begin
    if (rd_sh[2] && exp_q.size() != 0) begin
      logic [DW-1:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, rdata, e);
    end
  end

  task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic chk, input logic [DW-1:0] exp, input string tag);
    @(negedge clk);
    write_read = wr;
    address    = a;
    wdata      = d;
    fault_load = 1'b0;
    rd_issue   = chk;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, a, d, 1'b0, '0, "");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    drive(1'b0, a, '0, 1'b1, exp, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, IDLE_ADDR, '0, 1'b0, '0, "");
  endtask

  task automatic load(input logic [2:0] t, input logic [AW-1:0] a, input logic [2:0] b);
    @(negedge clk);
    write_read = 1'b0;
    address    = IDLE_ADDR;
    wdata      = '0;
    rd_issue   = 1'b0;
    fault_load = 1'b1;
    fault_type = t;
    fault_addr = a;
    fault_bit  = b;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_hits;
    rst        = 1'b1;
    write_read = 1'b0;
    address    = IDLE_ADDR;
    wdata      = '0;
    fault_load = 1'b0;
    fault_type = '0;
    fault_addr = '0;
    fault_bit  = '0;

    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_armed", fault_armed, 0);
    check("rst_hits", fault_hits, 0);
    rst = 1'b0;

    for (int a = 0; a < 16; a++) wr(AW'(a), 8'h00);
    idle(3);

    // Fault-free write/read with exact latency
    idle(1);
    wr(3, 8'hA5);
    rd(3, 8'hA5, "t0_rd3");
    idle(1);
    @(negedge clk);
    check("t0_lat1", rdata, 8'h00);
    idle(3);

    // Stuck-at-1 on addr 5 bit 0
    load(2, 5, 0);
    wr(5, 8'h00);
    rd(5, 8'h01, "sa1_rd5");
    idle(3);
    check("sa1_armed", fault_armed, 1);
`ifdef FAULT_MEM_HIT_CNT_EN
    exp_hits = 8'd1;
`else
    exp_hits = 8'd0;
`endif
    check("sa1_hits", fault_hits, exp_hits);
    rd(4, 8'h00, "sa1_nonvictim");
    idle(3);

    // NPSF on addr 4 bit 1, then at the edge address 0
    load(6, 4, 1);
    wr(3, 8'h02);
    wr(5, 8'h02);
    wr(4, 8'hFF);
    rd(4, 8'hFD, "npsf_rd4");
    rd(3, 8'h02, "npsf_rd3");
    load(6, 0, 1);
    wr(1, 8'h02);
    wr(0, 8'hFF);
    rd(0, 8'hFF, "npsf_rd0");
    idle(3);

    // Coupling: aggressor 6 bit 2 rising sets victim 7 bit 2; victim 0 has no aggressor
    load(5, 7, 2);
    wr(7, 8'h00);
    wr(6, 8'h04);
    rd(7, 8'h04, "cpl_rd7");
    rd(6, 8'h04, "cpl_rd6");
    load(5, 0, 2);
    wr(0, 8'h00);
    wr(15, 8'h00);
    wr(15, 8'h04);
    rd(0, 8'h00, "cpl_rd0");
    idle(3);

    // Transition faults and stuck-at-0
    load(3, 8, 7);
    wr(8, 8'h00);
    wr(8, 8'hFF);
    rd(8, 8'h7F, "tup_rd8");
    load(4, 9, 0);
    wr(9, 8'hFF);
    wr(9, 8'h00);
    rd(9, 8'h01, "tdn_rd9");
    load(1, 10, 7);
    wr(10, 8'hFF);
    rd(10, 8'h7F, "sa0_rd10");
    idle(3);

    // A load landing on the commit edge does not affect that write
    load(3, 12, 0);
    wr(12, 8'h01);
    load(0, 0, 0);
    rd(12, 8'h00, "cfg_edge_rd12");
    idle(3);
    check("cfg_none_armed", fault_armed, 0);

    // Back-to-back write then read, then reset between request and commit
    wr(2, 8'h3C);
    rd(2, 8'h3C, "fwd_rd2");
    idle(4);
    wr(2, 8'h99);
    @(negedge clk);
    rst        = 1'b1;
    write_read = 1'b0;
    address    = IDLE_ADDR;
    rd_issue   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_rdata", rdata, 0);
    rst = 1'b0;
    rd(2, 8'h3C, "rst_mid_rd2");
    idle(4);

    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
